// File: rtl/dp_issue_ctrl.sv
// Issue/writeback controller for ARM data-processing instructions driving an external ALU.
// Optional feature: define DP_SHIFTER_CARRY_EN so logical ops take C from the shifter carry-out.
module dp_issue_ctrl #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            flush,
  output logic [3:0]      alu_opcode,
  output logic            alu_setflags,
  output logic [XLEN-1:0] alu_dataa,
  output logic [XLEN-1:0] alu_datab,
  output logic [3:0]      alu_flagsin,
  input  logic            alu_writeback,
  input  logic [XLEN-1:0] alu_dataout,
  input  logic [3:0]      alu_flagsout,
  output logic [3:0]      flags,
  output logic            done,
  output logic            illegal,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [3:0]      flags_q, flags_d, cond_q, cond_d, op_q, op_d, rd_q, rd_d, nzcv_q, nzcv_d;
  logic            s_q, s_d, wb_q, wb_d, pass_q, pass_d, illegal_q, illegal_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic            accept, is_illegal, flag_upd;
  logic [XLEN-1:0] rm, sh_res;
  logic [4:0]      sh_amt, rot_amt;
  logic [63:0]     dbl;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cc;
      4'b0011: cond_pass = !cc;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cc && !z;
      4'b1001: cond_pass = !cc || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign accept     = (state_q == StIdle) && instr_valid && !flush;
  assign is_illegal = (instr[27:26] != 2'b00) || (!instr[25] && instr[4]);
  assign rm         = regs_q[instr[3:0]];
  assign sh_amt     = instr[11:7];
  assign rot_amt    = {instr[11:8], 1'b0};

  // Operand2 value; zero shift amounts encode LSR/ASR #32 and RRX.
  always_comb begin
    dbl    = '0;
    sh_res = '0;
    if (instr[25]) begin
      dbl    = {24'b0, instr[7:0], 24'b0, instr[7:0]} >> rot_amt;
      sh_res = dbl[31:0];
    end else begin
      case (instr[6:5])
        2'b00: sh_res = rm << sh_amt;
        2'b01: sh_res = (sh_amt == 5'd0) ? '0 : rm >> sh_amt;
        2'b10: sh_res = (sh_amt == 5'd0) ? {XLEN{rm[31]}} : 32'($signed(rm) >>> sh_amt);
        default: begin
          dbl    = {rm, rm} >> sh_amt;
          sh_res = (sh_amt == 5'd0) ? {flags_q[1], rm[31:1]} : dbl[31:0];
        end
      endcase
    end
  end

`ifdef DP_SHIFTER_CARRY_EN
  logic       sh_carry, shc_q, shc_d, logical_op;
  logic [4:0] lsl_idx;

  assign lsl_idx = 5'd0 - sh_amt;
  assign logical_op = (op_q[3:1] == 3'b000) || (op_q[3:1] == 3'b100) || (op_q[3:2] == 2'b11);

  always_comb begin
    sh_carry = flags_q[1];
    if (instr[25]) begin
      sh_carry = (rot_amt == 5'd0) ? flags_q[1] : sh_res[31];
    end else if (sh_amt == 5'd0) begin
      case (instr[6:5])
        2'b00:   sh_carry = flags_q[1];
        2'b11:   sh_carry = rm[0];
        default: sh_carry = rm[31];
      endcase
    end else begin
      sh_carry = (instr[6:5] == 2'b00) ? rm[lsl_idx] : rm[sh_amt - 5'd1];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      regs_q    <= '{default: '0};
      flags_q   <= '0;
      cond_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      s_q       <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      nzcv_q    <= '0;
      wb_q      <= 1'b0;
      pass_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DP_SHIFTER_CARRY_EN
      shc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      flags_q   <= flags_d;
      cond_q    <= cond_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      s_q       <= s_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      nzcv_q    <= nzcv_d;
      wb_q      <= wb_d;
      pass_q    <= pass_d;
      illegal_q <= illegal_d;
`ifdef DP_SHIFTER_CARRY_EN
      shc_q     <= shc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !is_illegal) state_d = StExec;
      StExec:  state_d = flush ? StIdle : StWb;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    regs_d    = regs_q;
    flags_d   = flags_q;
    cond_d    = cond_q;
    op_d      = op_q;
    rd_d      = rd_q;
    s_d       = s_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    nzcv_d    = nzcv_q;
    wb_d      = wb_q;
    pass_d    = pass_q;
    illegal_d = 1'b0;
    flag_upd  = s_q || (op_q[3:2] == 2'b10);
`ifdef DP_SHIFTER_CARRY_EN
    shc_d     = shc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
          end else begin
            cond_d = instr[31:28];
            op_d   = instr[24:21];
            s_d    = instr[20];
            rd_d   = instr[15:12];
            opa_d  = regs_q[instr[19:16]];
            opb_d  = sh_res;
`ifdef DP_SHIFTER_CARRY_EN
            shc_d  = sh_carry;
`endif
          end
        end
      end
      StExec: begin
        res_d  = alu_dataout;
        wb_d   = alu_writeback;
        nzcv_d = alu_flagsout;
        pass_d = cond_pass(cond_q, flags_q);
      end
      default: begin
        if (!flush && pass_q) begin
          if (wb_q) regs_d[rd_q] = res_q;
          if (flag_upd) begin
            flags_d = nzcv_q;
`ifdef DP_SHIFTER_CARRY_EN
            if (logical_op) flags_d[1] = shc_q;
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    instr_ready  = (state_q == StIdle);
    done         = (state_q == StWb) && !flush;
    illegal      = illegal_q;
    alu_opcode   = op_q;
    alu_setflags = s_q;
    alu_dataa    = opa_q;
    alu_datab    = opb_q;
    alu_flagsin  = flags_q;
    flags        = flags_q;
    dbg_data     = regs_q[dbg_addr];
  end

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed bench for dp_issue_ctrl with a behavioural ARM ALU attached to its ALU ports.
module tb_dp_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        flush = 1'b0;
  logic [3:0]  alu_opcode;
  logic        alu_setflags;
  logic [31:0] alu_dataa, alu_datab;
  logic [3:0]  alu_flagsin;
  logic        alu_writeback;
  logic [31:0] alu_dataout;
  logic [3:0]  alu_flagsout;
  logic [3:0]  flags;
  logic        done, illegal;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ill_cnt  = 0;

  dp_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .flush        (flush),
    .alu_opcode   (alu_opcode),
    .alu_setflags (alu_setflags),
    .alu_dataa    (alu_dataa),
    .alu_datab    (alu_datab),
    .alu_flagsin  (alu_flagsin),
    .alu_writeback(alu_writeback),
    .alu_dataout  (alu_dataout),
    .alu_flagsout (alu_flagsout),
    .flags        (flags),
    .done         (done),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic [31:0] ax, ay, lr, rr;
  logic        aci, arith, co, vo;
  logic [32:0] sum;
  always_comb begin
    ax = alu_dataa; ay = alu_datab; aci = 1'b0; arith = 1'b1; lr = '0;
    case (alu_opcode)
      4'd2, 4'd10: begin ay = ~alu_datab; aci = 1'b1; end
      4'd3: begin ax = alu_datab; ay = ~alu_dataa; aci = 1'b1; end
      4'd4, 4'd11: ;
      4'd5: aci = alu_flagsin[1];
      4'd6: begin ay = ~alu_datab; aci = alu_flagsin[1]; end
      4'd7: begin ax = alu_datab; ay = ~alu_dataa; aci = alu_flagsin[1]; end
      default: arith = 1'b0;
    endcase
    case (alu_opcode)
      4'd0, 4'd8: lr = alu_dataa & alu_datab;
      4'd1, 4'd9: lr = alu_dataa ^ alu_datab;
      4'd12: lr = alu_dataa | alu_datab;
      4'd13: lr = alu_datab;
      4'd14: lr = alu_dataa & ~alu_datab;
      default: lr = ~alu_datab;
    endcase
    sum = {1'b0, ax} + {1'b0, ay} + {32'b0, aci};
    rr  = arith ? sum[31:0] : lr;
    co  = arith ? sum[32] : alu_flagsin[1];
    vo  = arith ? ((ax[31] == ay[31]) && (rr[31] != ax[31])) : alu_flagsin[0];
    alu_dataout   = rr;
    alu_flagsout  = {rr[31], rr == 32'd0, co, vo};
    alu_writeback = (alu_opcode[3:2] != 2'b10);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (illegal) ill_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Issue one word; reports cycle offset of done, done/illegal pulse counts, ready at T+3.
  task automatic issue(input logic [31:0] w, output int lat, output int nd, output int ni,
                       output logic rdy3);
    @(posedge clk) #1;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk) #1;
    instr_valid = 1'b0;
    lat = -1; nd = 0; ni = 0; rdy3 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (illegal) ni++;
      if (c == 3) rdy3 = instr_ready;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({instr_ready, done, illegal, flags} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 1000000", {instr_ready, done, illegal, flags});
    end
    n_checks++;
    if ({alu_opcode, alu_setflags, alu_dataa, alu_datab} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_alu_drive: got %h expected 0", {alu_opcode, alu_setflags, alu_dataa, alu_datab});
    end
    read_reg(4'd15, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_r15: got %h expected 0", d); end
  endtask

  task automatic test_mov_imm();
    int lat, nd, ni; logic rdy3; logic [31:0] d;
    issue(32'hE3A010FF, lat, nd, ni, rdy3);
    n_checks++;
    if (lat !== 2 || nd !== 1 || rdy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL mov_latency: got lat=%0d nd=%0d rdy3=%b expected lat=2 nd=1 rdy3=1", lat, nd, rdy3);
    end
    read_reg(4'd1, d);
    n_checks++;
    if (d !== 32'h000000FF) begin n_fail++; $display("FAIL mov_r1: got %h expected 000000ff", d); end
    n_checks++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL mov_flags: got %b expected 0000", flags); end
    issue(32'hE3A024FF, lat, nd, ni, rdy3);
    read_reg(4'd2, d);
    n_checks++;
    if (d !== 32'hFF000000 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL mov_ror8: got r2=%h flags=%b expected ff000000 0000", d, flags);
    end
  endtask

  task automatic test_cmp_cond();
    int lat, nd, ni; logic rdy3; logic [31:0] d;
    issue(32'hE1510001, lat, nd, ni, rdy3);
    read_reg(4'd0, d);
    n_checks++;
    if (flags !== 4'b0110 || d !== 32'd0 || nd !== 1) begin
      n_fail++;
      $display("FAIL cmp: got flags=%b r0=%h nd=%0d expected 0110 0 1", flags, d, nd);
    end
    issue(32'h10813001, lat, nd, ni, rdy3);
    read_reg(4'd3, d);
    n_checks++;
    if (d !== 32'd0 || nd !== 1 || lat !== 2 || flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL addne_skip: got r3=%h nd=%0d lat=%0d flags=%b expected 0 1 2 0110",
               d, nd, lat, flags);
    end
  endtask

  task automatic test_illegal();
    int lat, nd, ni; logic rdy3; logic [31:0] d;
    int base;
    base = ill_cnt;
    issue(32'hE0813112, lat, nd, ni, rdy3);
    read_reg(4'd1, d);
    n_checks++;
    if (ni !== 1 || nd !== 0 || ill_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL illegal_pulse: got ni=%0d nd=%0d expected 1 0", ni, nd);
    end
    n_checks++;
    if (d !== 32'hFF || flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL illegal_nochange: got r1=%h flags=%b expected ff 0110", d, flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d5, d6; int base;
    base = done_cnt;
    @(posedge clk) #1;
    instr = 32'hE3A05005; instr_valid = 1'b1;
    @(posedge clk) #1;
    instr = 32'hE3A06006;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", instr_ready); end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk) #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    read_reg(4'd5, d5);
    read_reg(4'd6, d6);
    n_checks++;
    if (done_cnt - base !== 2 || d5 !== 32'd5 || d6 !== 32'd6) begin
      n_fail++;
      $display("FAIL busy_hold: got dones=%0d r5=%h r6=%h expected 2 5 6", done_cnt - base, d5, d6);
    end
  endtask

  task automatic test_shifts();
    int lat, nd, ni; logic rdy3; logic [31:0] d;
    issue(32'hE1B07022, lat, nd, ni, rdy3);
    read_reg(4'd7, d);
    n_checks++;
    if (d !== 32'd0 || flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL lsr32: got r7=%h flags=%b expected 0 0110", d, flags);
    end
    issue(32'hE1A09061, lat, nd, ni, rdy3);
    read_reg(4'd9, d);
    n_checks++;
    if (d !== 32'h8000007F) begin n_fail++; $display("FAIL rrx: got %h expected 8000007f", d); end
    issue(32'hE1A0A242, lat, nd, ni, rdy3);
    read_reg(4'd10, d);
    n_checks++;
    if (d !== 32'hFFF00000) begin n_fail++; $display("FAIL asr4: got %h expected fff00000", d); end
    issue(32'hE0811081, lat, nd, ni, rdy3);
    read_reg(4'd1, d);
    n_checks++;
    if (d !== 32'h000002FD) begin n_fail++; $display("FAIL add_rd_eq_rn: got %h expected 000002fd", d); end
  endtask

  task automatic test_reset_exec();
    logic [31:0] d1, d4; int base;
    base = done_cnt;
    @(posedge clk) #1;
    instr = 32'hE3A04001; instr_valid = 1'b1;
    @(posedge clk) #1;
    instr_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    read_reg(4'd4, d4);
    read_reg(4'd1, d1);
    n_checks++;
    if (done_cnt !== base || d4 !== 32'd0 || d1 !== 32'd0 || flags !== 4'b0000 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_exec: got dones=%0d r4=%h r1=%h flags=%b rdy=%b expected 0 0 0 0000 1",
               done_cnt - base, d4, d1, flags, instr_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d; int base; int lat, nd, ni; logic rdy3;
    base = done_cnt;
    @(posedge clk) #1;
    instr = 32'hE3A04001; instr_valid = 1'b1;
    @(posedge clk) #1;
    instr_valid = 1'b0; flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_reg(4'd4, d);
    n_checks++;
    if (done_cnt !== base || d !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_exec: got dones=%0d r4=%h expected 0 0", done_cnt - base, d);
    end
    instr_valid = 1'b1; flush = 1'b1;
    @(posedge clk) #1;
    instr_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %b expected 1", instr_ready); end
    repeat (3) @(posedge clk);
    #1;
    read_reg(4'd4, d);
    n_checks++;
    if (done_cnt !== base || d !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_idle: got dones=%0d r4=%h expected 0 0", done_cnt - base, d);
    end
    @(posedge clk) #1;
    instr_valid = 1'b1;
    @(posedge clk) #1;
    instr_valid = 1'b0;
    @(posedge clk) #1;
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL flush_wb_done: got %b expected 0", done); end
    @(posedge clk) #1;
    flush = 1'b0;
    read_reg(4'd4, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL flush_wb_write: got %h expected 0", d); end
    issue(32'hE3A04001, lat, nd, ni, rdy3);
    read_reg(4'd4, d);
    n_checks++;
    if (d !== 32'd1 || nd !== 1) begin
      n_fail++;
      $display("FAIL post_flush_mov: got r4=%h nd=%0d expected 1 1", d, nd);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_cmp_cond();
    test_illegal();
    test_back_to_back();
    test_shifts();
    test_reset_exec();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
